// File: rtl/ppm_slot_detector.sv
// rtl/ppm_slot_detector.sv - PPM slot counter and symbol resolver with a 2-deep observation FIFO
// Optional build macro: MULTI_HIT_FIRST_EN (multi-hit frames report the earliest hit instead of erasure)
module ppm_slot_detector #(
   parameter int M_SLOTS     = 1024,
   parameter int SLOT_W      = 10,
   parameter int GUARD_SLOTS = 256,
   parameter int N_SYM       = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              slot_tick,
   input  logic              photon_det,
   input  logic              sym_sync,
   output logic              obs_valid,
   output logic [SLOT_W:0]   obs_data,
   input  logic              obs_ready,
   output logic              obs_last,
   output logic              overflow,
   input  logic              clr_ovf
);

   // A zero-length guard still needs a one-bit counter to keep the logic legal.
   localparam int GUARD_W = (GUARD_SLOTS > 0) ? $clog2(GUARD_SLOTS + 1) : 1;
   localparam int SYM_W   = (N_SYM > 1) ? $clog2(N_SYM) : 1;

   localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(M_SLOTS - 1);
   localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'((GUARD_SLOTS > 0) ? GUARD_SLOTS - 1 : 0);
   localparam logic [SYM_W-1:0]   SYM_LAST   = SYM_W'(N_SYM - 1);
   localparam logic [SLOT_W:0]    ERASURE    = (SLOT_W + 1)'(M_SLOTS);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SLOTS   = 2'd1,
      RESOLVE = 2'd2,
      GUARD   = 2'd3
   } state_t;

   state_t              state;
   logic [SLOT_W-1:0]   slot_cnt;
   logic [GUARD_W-1:0]  guard_cnt;
   logic [1:0]          hit_cnt;
   logic [SLOT_W-1:0]   first_idx;
   logic [SYM_W-1:0]    sym_cnt;

   logic [1:0]          hit_next;
   logic [SLOT_W:0]     res_data;
   logic                res_last;

   logic                sk_valid;
   logic [SLOT_W:0]     sk_data;
   logic                sk_last;

   logic                push;
   logic                pop;
   logic                full;
   logic                accept;
   logic                drop;

   // Saturating hit count and the resolved observation for the symbol just completed.
   always_comb begin
      hit_next = (hit_cnt == 2'd2) ? 2'd2 : hit_cnt + 2'd1;
      res_data = ERASURE;
`ifdef MULTI_HIT_FIRST_EN
      if (hit_cnt != 2'd0) begin
         res_data = {1'b0, first_idx};
      end
`else
      if (hit_cnt == 2'd1) begin
         res_data = {1'b0, first_idx};
      end
`endif
      res_last = (sym_cnt == SYM_LAST);
   end

   // FIFO handshake terms; the RESOLVE cycle is the single push opportunity per symbol.
   always_comb begin
      push   = (state == RESOLVE);
      pop    = obs_valid && obs_ready;
      full   = obs_valid && sk_valid;
      accept = push && (!full || pop);
      drop   = push && full && !pop;
   end

   // Frame state machine: slot counting, guard skipping and resync handling.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         slot_cnt  <= '0;
         guard_cnt <= '0;
         hit_cnt   <= 2'd0;
         first_idx <= '0;
      end else if (!enable) begin
         state     <= IDLE;
         slot_cnt  <= '0;
         guard_cnt <= '0;
         hit_cnt   <= 2'd0;
         first_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               state     <= SLOTS;
               slot_cnt  <= '0;
               guard_cnt <= '0;
               hit_cnt   <= 2'd0;
            end

            SLOTS: begin
               if (slot_tick) begin
                  if (sym_sync) begin
                     // Resync tick is slot 0 of a fresh symbol, detection included.
                     slot_cnt  <= SLOT_W'(1);
                     hit_cnt   <= photon_det ? 2'd1 : 2'd0;
                     first_idx <= '0;
                  end else begin
                     slot_cnt <= slot_cnt + SLOT_W'(1);
                     if (photon_det) begin
                        if (hit_cnt == 2'd0) begin
                           first_idx <= slot_cnt;
                        end
                        hit_cnt <= hit_next;
                     end
                     if (slot_cnt == SLOT_LAST) begin
                        state <= RESOLVE;
                     end
                  end
               end
            end

            RESOLVE: begin
               // A tick arriving while resolving is not lost: it is slot 0 of the
               // next symbol (no guard or resync) or the first guard tick.
               slot_cnt  <= '0;
               guard_cnt <= '0;
               hit_cnt   <= 2'd0;
               if (slot_tick && (sym_sync || GUARD_SLOTS == 0)) begin
                  state     <= SLOTS;
                  slot_cnt  <= SLOT_W'(1);
                  hit_cnt   <= photon_det ? 2'd1 : 2'd0;
                  first_idx <= '0;
               end else if (GUARD_SLOTS == 0) begin
                  state <= SLOTS;
               end else if (slot_tick && (GUARD_LAST == '0)) begin
                  state <= SLOTS;
               end else begin
                  state     <= GUARD;
                  guard_cnt <= slot_tick ? GUARD_W'(1) : '0;
               end
            end

            GUARD: begin
               if (slot_tick) begin
                  if (sym_sync) begin
                     state     <= SLOTS;
                     slot_cnt  <= SLOT_W'(1);
                     hit_cnt   <= photon_det ? 2'd1 : 2'd0;
                     first_idx <= '0;
                     guard_cnt <= '0;
                  end else if (guard_cnt == GUARD_LAST) begin
                     state     <= SLOTS;
                     slot_cnt  <= '0;
                     hit_cnt   <= 2'd0;
                     guard_cnt <= '0;
                  end else begin
                     guard_cnt <= guard_cnt + GUARD_W'(1);
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Two-entry output queue: head register drives the ports, skid entry holds the second.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         obs_valid <= 1'b0;
         obs_data  <= '0;
         obs_last  <= 1'b0;
         sk_valid  <= 1'b0;
         sk_data   <= '0;
         sk_last   <= 1'b0;
      end else if (pop) begin
         if (sk_valid) begin
            obs_data <= sk_data;
            obs_last <= sk_last;
            sk_valid <= accept;
            if (accept) begin
               sk_data <= res_data;
               sk_last <= res_last;
            end
         end else begin
            obs_valid <= accept;
            if (accept) begin
               obs_data <= res_data;
               obs_last <= res_last;
            end
         end
      end else if (accept) begin
         if (!obs_valid) begin
            obs_valid <= 1'b1;
            obs_data  <= res_data;
            obs_last  <= res_last;
         end else begin
            sk_valid <= 1'b1;
            sk_data  <= res_data;
            sk_last  <= res_last;
         end
      end
   end

   // Block position advances only for symbols that actually entered the queue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sym_cnt <= '0;
      end else if (accept) begin
         sym_cnt <= (sym_cnt == SYM_LAST) ? '0 : sym_cnt + SYM_W'(1);
      end
   end

   // Sticky drop flag; a new drop beats a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ppm_slot_detector.sv
// tb/tb_ppm_slot_detector.sv - directed vector bench for ppm_slot_detector
module tb_ppm_slot_detector;

   localparam int M  = 1024;
   localparam int G  = 256;
   localparam int NS = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        slot_tick = 1'b0;
   logic        photon_det = 1'b0;
   logic        sym_sync = 1'b0;
   logic        obs_ready = 1'b1;
   logic        clr_ovf = 1'b0;
   logic        ready_b = 1'b1;

   logic        obs_valid;
   logic [10:0] obs_data;
   logic        obs_last;
   logic        overflow;

   logic        obs_valid_b;
   logic [10:0] obs_data_b;
   logic        obs_last_b;
   logic        overflow_b;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      int data;
      int last;
      int cyc;
   } cap_t;

   typedef struct {
      int hit_a;
      int hit_b;
      int ghit;
      int exp_data;
      int exp_last;
   } vec_t;

   cap_t qa[$];
   cap_t qb[$];

   ppm_slot_detector #(.M_SLOTS(M), .SLOT_W(10), .GUARD_SLOTS(G), .N_SYM(NS)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .slot_tick(slot_tick),
      .photon_det(photon_det), .sym_sync(sym_sync), .obs_valid(obs_valid),
      .obs_data(obs_data), .obs_ready(obs_ready), .obs_last(obs_last),
      .overflow(overflow), .clr_ovf(clr_ovf)
   );

   ppm_slot_detector #(.M_SLOTS(M), .SLOT_W(10), .GUARD_SLOTS(0), .N_SYM(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .enable(enable), .slot_tick(slot_tick),
      .photon_det(photon_det), .sym_sync(sym_sync), .obs_valid(obs_valid_b),
      .obs_data(obs_data_b), .obs_ready(ready_b), .obs_last(obs_last_b),
      .overflow(overflow_b), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      cap_t c;
      if (obs_valid && obs_ready) begin
         c.data = int'(obs_data);
         c.last = int'(obs_last);
         c.cyc  = cyc;
         qa.push_back(c);
      end
      if (obs_valid_b && ready_b) begin
         c.data = int'(obs_data_b);
         c.last = int'(obs_last_b);
         c.cyc  = cyc;
         qb.push_back(c);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step(input bit tk, input bit det, input bit sy);
      slot_tick  = tk;
      photon_det = det;
      sym_sync   = sy;
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input int ha, input int hb, input int gh, input bit raise_rdy,
                            output int t_final);
      t_final = 0;
      for (int s = 0; s < M; s++) begin
         if (s == M - 1) t_final = cyc;
         step(1'b1, (s == ha) || (s == hb), 1'b0);
      end
      if (raise_rdy) obs_ready = 1'b1;
      for (int g = 0; g < G; g++) step(1'b1, g == gh, 1'b0);
      slot_tick = 1'b0;
   endtask

   task automatic expect_obs(input string nm, input int d, input int l, output int cap_cyc);
      cap_t c;
      cap_cyc = -1;
      if (qa.size() == 0) begin
         check({nm, " present"}, 0, 1);
      end else begin
         c = qa.pop_front();
         check({nm, " data"}, c.data, d);
         check({nm, " last"}, c.last, l);
         cap_cyc = c.cyc;
      end
   endtask

   initial begin
      vec_t vecs[9];
      int   t_fin;
      int   cap;
      int   multi_5_900;
      int   multi_1_2;
      cap_t cb;

`ifdef MULTI_HIT_FIRST_EN
      multi_5_900 = 5;
      multi_1_2   = 1;
`else
      multi_5_900 = 1024;
      multi_1_2   = 1024;
`endif
      //            hit_a hit_b ghit  exp_data     exp_last
      vecs[0] = '{  37,   -1,   -1,   37,          0};
      vecs[1] = '{  -1,   -1,   -1,   1024,        0};
      vecs[2] = '{   5,  900,    3,   multi_5_900, 0};
      vecs[3] = '{1023,   -1,   -1,   1023,        1};
      vecs[4] = '{   0,   -1,   -1,   0,           0};
      vecs[5] = '{1022,   -1,   -1,   1022,        0};
      vecs[6] = '{ 512,   -1,   -1,   512,         0};
      vecs[7] = '{   1,    2,   -1,   multi_1_2,   1};
      vecs[8] = '{ 700,   -1,   -1,   700,         0};

      // Reset state
      #1;
      check("reset obs_valid", int'(obs_valid), 0);
      check("reset obs_data", int'(obs_data), 0);
      check("reset obs_last", int'(obs_last), 0);
      check("reset overflow", int'(overflow), 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      enable = 1'b1;
      step(1'b0, 1'b0, 1'b0);

      // Table of single frames with the consumer always ready
      for (int i = 0; i < 9; i++) begin
         run_frame(vecs[i].hit_a, vecs[i].hit_b, vecs[i].ghit, 1'b0, t_fin);
         check($sformatf("vec%0d count", i), qa.size(), 1);
         expect_obs($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_last, cap);
         check($sformatf("vec%0d latency", i), cap - t_fin, 2);
      end

      // Back-pressure: 10 and 20 held, 30 dropped (block position 1,2 used; 3 still free)
      obs_ready = 1'b0;
      run_frame(10, -1, -1, 1'b0, t_fin);
      check("hold head after 10", int'(obs_data), 10);
      run_frame(20, -1, -1, 1'b0, t_fin);
      run_frame(30, -1, -1, 1'b0, t_fin);
      check("ovf set", int'(overflow), 1);
      check("ovf valid held", int'(obs_valid), 1);
      check("ovf head stable", int'(obs_data), 10);
      clr_ovf = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      clr_ovf = 1'b0;
      check("ovf cleared", int'(overflow), 0);
      obs_ready = 1'b1;
      repeat (3) step(1'b0, 1'b0, 1'b0);
      check("ovf drained count", qa.size(), 2);
      expect_obs("ovf first", 10, 0, cap);
      expect_obs("ovf second", 20, 0, cap);
      run_frame(40, -1, -1, 1'b0, t_fin);
      expect_obs("after drop", 40, 1, cap);

      // Full queue with push and pop in the same cycle
      obs_ready = 1'b0;
      run_frame(50, -1, -1, 1'b0, t_fin);
      run_frame(60, -1, -1, 1'b0, t_fin);
      run_frame(70, -1, -1, 1'b1, t_fin);
      check("pushpop ovf", int'(overflow), 0);
      check("pushpop count", qa.size(), 3);
      expect_obs("pushpop a", 50, 0, cap);
      expect_obs("pushpop b", 60, 0, cap);
      expect_obs("pushpop c", 70, 0, cap);

      // Resync mid-frame: hit at 100 discarded, sync tick carries a hit as slot 0
      for (int s = 0; s < 500; s++) step(1'b1, s == 100, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      for (int s = 1; s < M; s++) begin
         if (s == M - 1) t_fin = cyc;
         step(1'b1, 1'b0, 1'b0);
      end
      for (int g = 0; g < G; g++) step(1'b1, 1'b0, 1'b0);
      slot_tick = 1'b0;
      check("sync count", qa.size(), 1);
      expect_obs("sync", 0, 1, cap);
      check("sync latency", cap - t_fin, 2);

      // Asynchronous reset in the middle of a frame
      obs_ready = 1'b0;
      run_frame(77, -1, -1, 1'b0, t_fin);
      check("pre-reset valid", int'(obs_valid), 1);
      check("pre-reset data", int'(obs_data), 77);
      for (int s = 0; s < 600; s++) step(1'b1, s == 200, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset valid", int'(obs_valid), 0);
      check("async reset data", int'(obs_data), 0);
      check("async reset last", int'(obs_last), 0);
      check("async reset ovf", int'(overflow), 0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      obs_ready = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      run_frame(300, -1, -1, 1'b0, t_fin);
      check("fresh count", qa.size(), 1);
      expect_obs("fresh", 300, 0, cap);
      check("fresh latency", cap - t_fin, 2);

      // Zero-guard instance: three back-to-back frames, tick every cycle
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      qb.delete();
      for (int k = 0; k < 3 * M; k++)
         step(1'b1, (k == 11) || (k == M + 22) || (k == 2 * M + 33), 1'b0);
      slot_tick = 1'b0;
      repeat (5) step(1'b0, 1'b0, 1'b0);
      check("b2b count", qb.size(), 3);
      check("b2b ovf", int'(overflow_b), 0);
      if (qb.size() == 3) begin
         cb = qb[0];
         check("b2b s0 data", cb.data, 11);
         check("b2b s0 last", cb.last, 0);
         cb = qb[1];
         check("b2b s1 data", cb.data, 22);
         check("b2b s1 last", cb.last, 1);
         check("b2b spacing 1", qb[1].cyc - qb[0].cyc, M);
         cb = qb[2];
         check("b2b s2 data", cb.data, 33);
         check("b2b s2 last", cb.last, 0);
         check("b2b spacing 2", qb[2].cyc - qb[1].cyc, M);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
